// File: rtl/alu_sched.sv
// alu_sched: shares one lane-wise adder (alu) between two requesters.
// An operation passes through IDLE -> EXEC -> RESP, so the shortest issue interval is 3 cycles.
// Only one operation is in flight at a time.
// Optional build macro ALU_SCHED_FIXED_PRIO_EN: when it is defined, port 0 always wins
// contention and the round-robin pointer is not built.

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  width,
  input  logic        saturate,
  output logic [31:0] c
);

  logic [31:0] c8;
  logic [31:0] c16;
  logic [31:0] c32;
  logic [8:0]  s9;
  logic [16:0] s17;
  logic [32:0] s33;

  // Signed add in every lane layout at once; the sign-extended carry bit shows overflow.
  always_comb begin
    c8  = '0;
    c16 = '0;
    c32 = '0;
    s9  = '0;
    s17 = '0;
    s33 = '0;
    for (int i = 0; i < 4; i++) begin
      s9 = {a[8*i+7], a[8*i +: 8]} + {b[8*i+7], b[8*i +: 8]};
      if (saturate && (s9[8] != s9[7]))
        c8[8*i +: 8] = s9[8] ? 8'h80 : 8'h7f;
      else
        c8[8*i +: 8] = s9[7:0];
    end
    for (int j = 0; j < 2; j++) begin
      s17 = {a[16*j+15], a[16*j +: 16]} + {b[16*j+15], b[16*j +: 16]};
      if (saturate && (s17[16] != s17[15]))
        c16[16*j +: 16] = s17[16] ? 16'h8000 : 16'h7fff;
      else
        c16[16*j +: 16] = s17[15:0];
    end
    s33 = {a[31], a} + {b[31], b};
    if (saturate && (s33[32] != s33[31]))
      c32 = s33[32] ? 32'h8000_0000 : 32'h7fff_ffff;
    else
      c32 = s33[31:0];
  end

  // Choose the lane layout; width code 3 behaves like a single 32-bit lane.
  always_comb begin
    case (width)
      2'd0:    c = c8;
      2'd1:    c = c16;
      default: c = c32;
    endcase
  end

endmodule

module alu_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_b_1,
  input  logic [1:0]  req_width_0,
  input  logic [1:0]  req_width_1,
  input  logic        req_sat_0,
  input  logic        req_sat_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  output logic [31:0] rsp_data_0,
  output logic [31:0] rsp_data_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [15:0] done_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        owner;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  op_width;
  logic        op_sat;
  logic [31:0] rsp_reg;
  logic [31:0] alu_c;
  logic        gnt_0;
  logic        gnt_1;
  logic        accept;
  logic        rsp_fire;

  alu u_alu (
    .a        (op_a),
    .b        (op_b),
    .width    (op_width),
    .saturate (op_sat),
    .c        (alu_c)
  );

`ifdef ALU_SCHED_FIXED_PRIO_EN
  // Fixed priority: port 0 wins whenever it is asking.
  always_comb begin
    gnt_0 = req_valid_0;
    gnt_1 = req_valid_1 & ~req_valid_0;
  end
`else
  logic ptr;

  // Round robin: under contention the pointer picks the port that was not served last.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      gnt_0 = ~ptr;
      gnt_1 = ptr;
    end else begin
      gnt_0 = req_valid_0;
      gnt_1 = req_valid_1;
    end
  end

  // The pointer moves away from the port that just completed a response handshake.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (rsp_fire)
      ptr <= ~owner;
  end
`endif

  // Grants are offered only in IDLE and never while reset is held.
  always_comb begin
    req_ready_0 = rst_n && (state == IDLE) && gnt_0;
    req_ready_1 = rst_n && (state == IDLE) && gnt_1;
    accept      = (req_ready_0 & req_valid_0) | (req_ready_1 & req_valid_1);
    rsp_fire    = (state == RESP) && (owner ? rsp_ready_1 : rsp_ready_0);
  end

  // Sequencing, plus capture of the accepted operands and the requester id.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_width <= '0;
      op_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner    <= req_ready_1;
            op_a     <= req_ready_1 ? req_a_1 : req_a_0;
            op_b     <= req_ready_1 ? req_b_1 : req_b_0;
            op_width <= req_ready_1 ? req_width_1 : req_width_0;
            op_sat   <= req_ready_1 ? req_sat_1 : req_sat_0;
            state    <= EXEC;
          end
        end
        EXEC:    state <= RESP;
        RESP:    if (rsp_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The result is captured once, in EXEC, and is held for the whole of RESP.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rsp_reg <= '0;
    else if (state == EXEC)
      rsp_reg <= alu_c;
  end

  // Count completed responses; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n)
      done_cnt <= '0;
    else if (rsp_fire)
      done_cnt <= done_cnt + 16'd1;
  end

  // Only the owning port sees a valid response; the other port reads as zero.
  always_comb begin
    rsp_valid_0 = (state == RESP) && !owner;
    rsp_valid_1 = (state == RESP) && owner;
    rsp_data_0  = rsp_valid_0 ? rsp_reg : 32'd0;
    rsp_data_1  = rsp_valid_1 ? rsp_reg : 32'd0;
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and randomised checks of alu_sched against a lane-arithmetic model.
// The model tracks the port served last and the expected done_cnt.

module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [1:0]  req_width_0, req_width_1;
  logic        req_sat_0, req_sat_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic [31:0] rsp_data_0, rsp_data_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [15:0] done_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_done = 16'd0;
  int          last_served = -1;

  alu_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_a_0     (req_a_0),
    .req_a_1     (req_a_1),
    .req_b_0     (req_b_0),
    .req_b_1     (req_b_1),
    .req_width_0 (req_width_0),
    .req_width_1 (req_width_1),
    .req_sat_0   (req_sat_0),
    .req_sat_1   (req_sat_1),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_data_0  (rsp_data_0),
    .rsp_data_1  (rsp_data_1),
    .rsp_ready_0 (rsp_ready_0),
    .rsp_ready_1 (rsp_ready_1),
    .done_cnt    (done_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog so that the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  // Reference lane arithmetic: signed integer sums, clamped when saturating.
  function automatic logic [31:0] ref_add(logic [31:0] a, logic [31:0] b, logic [1:0] w, bit sat);
    int          lw;
    longint      half, full, x, y, s;
    logic [31:0] r;
    lw   = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    full = longint'(1) << lw;
    half = full / 2;
    r    = '0;
    for (int i = 0; i < 32 / lw; i++) begin
      x = longint'((a >> (i * lw)) & (full - 1));
      y = longint'((b >> (i * lw)) & (full - 1));
      if (x >= half) x = x - full;
      if (y >= half) y = y - full;
      s = x + y;
      if (sat && s > half - 1) s = half - 1;
      if (sat && s < -half)    s = -half;
      if (s < 0) s = s + full;
      r = r | (32'(s) << (i * lw));
    end
    return r;
  endfunction

  function automatic int exp_grant(bit v0, bit v1);
    if (v0 && v1) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      return 0;
`else
      return (last_served == 0) ? 1 : 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_port_valid(input int p, input logic v);
    if (p == 0) req_valid_0 = v; else req_valid_1 = v;
  endtask

  task automatic set_port_ready(input int p, input logic v);
    if (p == 0) rsp_ready_0 = v; else rsp_ready_1 = v;
  endtask

  // One full transaction starting in IDLE at posedge+1, with `hold` stall cycles in RESP.
  task automatic applyStimulus(input bit v0, input bit v1,
                               input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] w0, input bit s0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] w1, input bit s1,
                               input int hold);
    int          g;
    logic [31:0] exp_data;
    g        = exp_grant(v0, v1);
    exp_data = (g == 0) ? ref_add(a0, b0, w0, s0) : ref_add(a1, b1, w1, s1);
    req_a_0 = a0; req_b_0 = b0; req_width_0 = w0; req_sat_0 = s0;
    req_a_1 = a1; req_b_1 = b1; req_width_1 = w1; req_sat_1 = s1;
    req_valid_0 = v0; req_valid_1 = v1;
    @(negedge clk);
    checkOutput("grant_ready_0", 32'(req_ready_0), 32'(g == 0));
    checkOutput("grant_ready_1", 32'(req_ready_1), 32'(g == 1));
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_a_0 = $urandom; req_a_1 = $urandom; req_b_0 = $urandom; req_b_1 = $urandom;
    @(negedge clk);
    checkOutput("exec_no_valid", 32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    checkOutput("exec_no_ready", 32'({req_ready_1, req_ready_0}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("resp_valid", 32'({rsp_valid_1, rsp_valid_0}), (g == 0) ? 32'd1 : 32'd2);
    checkOutput("resp_data_own", (g == 0) ? rsp_data_0 : rsp_data_1, exp_data);
    checkOutput("resp_data_other", (g == 0) ? rsp_data_1 : rsp_data_0, 32'd0);
    for (int i = 0; i < hold; i++) begin
      set_port_valid(1 - g, 1'b1);
      set_port_ready(1 - g, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hold_valid", 32'({rsp_valid_1, rsp_valid_0}), (g == 0) ? 32'd1 : 32'd2);
      checkOutput("hold_data", (g == 0) ? rsp_data_0 : rsp_data_1, exp_data);
      checkOutput("hold_no_ready", 32'({req_ready_1, req_ready_0}), 32'd0);
      checkOutput("hold_done", 32'(done_cnt), 32'(exp_done));
    end
    set_port_valid(1 - g, 1'b0);
    set_port_ready(1 - g, 1'b0);
    set_port_ready(g, 1'b1);
    @(posedge clk); #1;
    set_port_ready(g, 1'b0);
    exp_done    = exp_done + 16'd1;
    last_served = g;
    @(negedge clk);
    checkOutput("after_hs_valid", 32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    checkOutput("after_hs_done", 32'(done_cnt), 32'(exp_done));
    @(posedge clk); #1;
  endtask

  initial begin
    int grants[$];
    int cycles;
    bit v0, v1;

    $display("[TB] starting alu_sched checks");
    rst_n = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
    req_width_0 = '0; req_width_1 = '0; req_sat_0 = 1'b0; req_sat_1 = 1'b0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset_ready", 32'({req_ready_1, req_ready_0}), 32'd0);
    checkOutput("reset_valid", 32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    checkOutput("reset_data0", rsp_data_0, 32'd0);
    checkOutput("reset_data1", rsp_data_1, 32'd0);
    checkOutput("reset_done", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    applyStimulus(1, 0, 32'h7fff_ffff, 32'h0000_0001, 2'd2, 0, 32'h0, 32'h0, 2'd0, 0, 0);
    applyStimulus(0, 1, 32'h0, 32'h0, 2'd0, 0, 32'h7fff_ffff, 32'h0000_0913, 2'd2, 1, 0);
    applyStimulus(1, 0, 32'h8001_017f, 32'hff01_017f, 2'd0, 1, 32'h0, 32'h0, 2'd0, 0, 0);
    applyStimulus(1, 0, 32'h8001_017f, 32'hff01_017f, 2'd0, 0, 32'h0, 32'h0, 2'd0, 0, 0);
    applyStimulus(1, 0, 32'h7fff_8000, 32'h0001_ffff, 2'd1, 1, 32'h0, 32'h0, 2'd0, 0, 0);
    applyStimulus(0, 1, 32'h0, 32'h0, 2'd0, 0, 32'h8000_0000, 32'hffff_ffff, 2'd3, 1, 0);
    applyStimulus(1, 0, 32'h1234_5678, 32'h1111_1111, 2'd2, 0, 32'h0, 32'h0, 2'd0, 0, 5);

    // Continuous contention with responses always consumed.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_done = 16'd0; last_served = -1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    cycles = 0;
    while (grants.size() < 4 && cycles < 20) begin
      @(negedge clk);
      if (req_ready_0) grants.push_back(0);
      else if (req_ready_1) grants.push_back(1);
      cycles++;
      if (grants.size() < 4) begin
        @(posedge clk); #1;
      end
    end
    checkOutput("rr_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      int e;
      int obs;
`ifdef ALU_SCHED_FIXED_PRIO_EN
      e = 0;
`else
      e = i % 2;
`endif
      obs = (i < grants.size()) ? grants[i] : -1;
      checkOutput("rr_grant_seq", 32'(obs), 32'(e));
    end
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    @(negedge clk);
    checkOutput("rr_done", 32'(done_cnt), 32'd4);
    exp_done = 16'd4;
    last_served = grants.size() > 0 ? grants[grants.size() - 1] : -1;
    @(posedge clk); #1;

    // Serve port 0 so the pointer favours port 1, then reset during EXEC.
    applyStimulus(1, 0, 32'h0000_0005, 32'h0000_0007, 2'd2, 0, 32'h0, 32'h0, 2'd0, 0, 0);
    req_a_0 = 32'h1; req_b_0 = 32'h2; req_width_0 = 2'd2; req_sat_0 = 1'b0;
    req_valid_0 = 1'b1;
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    rst_n = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    @(negedge clk);
    checkOutput("rst_exec_ready", 32'({req_ready_1, req_ready_0}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_exec_valid", 32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    checkOutput("rst_exec_done", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_done = 16'd0; last_served = -1;
    @(negedge clk);
    checkOutput("rst_prio_ready0", 32'(req_ready_0), 32'd1);
    checkOutput("rst_prio_ready1", 32'(req_ready_1), 32'd0);
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0;
    exp_done = 16'd1; last_served = 0;
    @(negedge clk);
    checkOutput("rst_after_done", 32'(done_cnt), 32'd1);
    @(posedge clk); #1;

    // Randomised transactions, including contention.
    for (int n = 0; n < 30; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      applyStimulus(v0, v1,
                    $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports req_valid_0 / req_valid_1  input  1  requester n has an operation pending.
REQ-004 SHALL have ports req_ready_0 / req_ready_1  output  1  scheduler accepts requester n this cycle.
REQ-005 SHALL have ports req_a_0 / req_a_1, req_b_0 / req_b_1  input  32  operands.
REQ-006 SHALL have ports req_width_0 / req_width_1  input  2  lane width: 0 = 4x8, 1 = 2x16, 2 = 1x32, 3 = treated as 2.
REQ-007 SHALL have ports req_sat_0 / req_sat_1  input  1  1 = saturating signed add, 0 = wrapping add.
REQ-008 SHALL have ports rsp_valid_0 / rsp_valid_1  output  1  result for requester n is available.
REQ-009 SHALL have ports rsp_data_0 / rsp_data_1  output  32  result.
REQ-010 SHALL have ports rsp_ready_0 / rsp_ready_1  input  1  requester n consumes the result.
REQ-011 SHALL have port done_cnt  output  16  count of completed responses.

Function
REQ-012 SHALL share one instance of the team's alu (ports a, b, width, saturate, c) between both requesters, with one operation outstanding at a time.
REQ-013 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-014 In IDLE, req_ready_n SHALL be 1 only for the granted requester; both ready outputs SHALL be 0 in EXEC and RESP.
REQ-015 Grant rule: one valid -> that port; both valid -> the port not served last (round-robin pointer).
REQ-016 An accept (valid & ready) SHALL register a, b, width, saturate and requester id, then move IDLE -> EXEC.
REQ-017 In EXEC the alu SHALL compute from the registered operands, c SHALL be captured into the response register, and the FSM SHALL move to RESP; rsp_valid_n rises 2 cycles after the accept edge.
REQ-018 In RESP, exactly one rsp_valid SHALL be 1 (the owner's), with rsp_data held stable until rsp_ready of the owner is 1.
REQ-019 Response handshake SHALL: return the FSM to IDLE, deassert rsp_valid next cycle, increment done_cnt (wrapping 0xFFFF -> 0x0000), and flip the round-robin pointer away from the served port.
REQ-020 No new request SHALL be accepted in the response-handshake cycle; minimum issue interval is 3 cycles.
REQ-021 rsp_ready of the non-owning port SHALL be ignored; rsp_data of the non-owning port SHALL read 0.
REQ-022 Lane arithmetic SHALL be exactly the alu's: per-lane signed add, independent lanes, clamp to 0x7F.. / 0x80.. when saturating.
REQ-023 A requester dropping req_valid before an accept SHALL cause no side effect.

Reset
REQ-024 With rst_n = 0 at a clock edge: FSM -> IDLE, all rsp_valid = 0, rsp_data = 0, done_cnt = 0, pointer favours port 0.
REQ-025 Reset in EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-026 While rst_n = 0, both req_ready outputs SHALL be 0.

Configuration
REQ-027 Macro ALU_SCHED_FIXED_PRIO_EN: when defined, port 0 SHALL always win contention and the pointer SHALL be removed; when undefined, round-robin per REQ-015/REQ-019.

Verification
REQ-028 Port0 a=0x7FFFFFFF b=0x00000001 width=2 sat=0 -> rsp_valid_0 2 cycles after accept, rsp_data_0=0x80000000, done_cnt=1.
REQ-029 Port1 a=0x7FFFFFFF b=0x00000913 width=2 sat=1 -> rsp_data_1=0x7FFFFFFF; rsp_valid_0 stays 0.
REQ-030 Port0 a=0x8001017F b=0xFF01017F width=0 sat=1 -> 0x8002027F; same with sat=0 -> 0x7F0202FE.
REQ-031 Both ports valid continuously, rsp_ready tied 1 -> grants 0,1,0,1; with ALU_SCHED_FIXED_PRIO_EN -> 0,0,0,0.
REQ-032 rsp_ready_0 held 0 for 5 cycles -> rsp_data_0 stable, both req_ready 0; consumed on cycle 6, done_cnt +1.
REQ-033 rst_n=0 during EXEC -> next cycle no rsp_valid, done_cnt=0, port0 wins subsequent contention.
